// File: rtl/xadc_channel_sequencer_if.sv
// Bundle of DRP master signals, EOC input and the tagged sample stream
// that connect the XADC channel sequencer to the ADC primitive and its consumer.
`timescale 1ns/1ps

interface xadc_channel_sequencer_if;
  logic        eoc_in;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [11:0] sample;
  logic [3:0]  sample_ch;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        timeout_err;

  // Sequencer side: owns the DRP and produces the sample stream.
  modport master (
    input  eoc_in,
    input  drp_drdy,
    input  drp_do,
    input  sample_ready,
    output drp_den,
    output drp_dwe,
    output drp_daddr,
    output sample,
    output sample_ch,
    output sample_valid,
    output busy,
    output timeout_err
  );

  // Environment side: ADC primitive plus the sample consumer.
  modport slave (
    output eoc_in,
    output drp_drdy,
    output drp_do,
    output sample_ready,
    input  drp_den,
    input  drp_dwe,
    input  drp_daddr,
    input  sample,
    input  sample_ch,
    input  sample_valid,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/xadc_channel_sequencer.sv
// Round-robin DRP reader: on each EOC sweeps NUM_CH status registers and
// emits every 12-bit result as a channel-tagged valid/ready sample.
`timescale 1ns/1ps

module xadc_channel_sequencer #(
  parameter int         NUM_CH    = 13,
  parameter logic [6:0] BASE_ADDR = 7'h10,
  parameter int         TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  xadc_channel_sequencer_if.master  bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state_reg,     state_next;
  logic [3:0]  idx_reg,       idx_next;
  logic [7:0]  tcnt_reg,      tcnt_next;
  logic        pending_reg,   pending_next;
  logic [11:0] sample_reg,    sample_next;
  logic [3:0]  sample_ch_reg, sample_ch_next;
  logic        advance;
  logic        timeout_hit;

  // The low nibble of a status register carries no conversion data.
  logic        unused_low_nibble;
  assign unused_low_nibble = ^bus.drp_do[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 4'd0;
      tcnt_reg      <= 8'd0;
      pending_reg   <= 1'b0;
      sample_reg    <= 12'd0;
      sample_ch_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      tcnt_reg      <= tcnt_next;
      pending_reg   <= pending_next;
      sample_reg    <= sample_next;
      sample_ch_reg <= sample_ch_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    tcnt_next      = tcnt_reg;
    sample_next    = sample_reg;
    sample_ch_next = sample_ch_reg;
    advance        = 1'b0;
    timeout_hit    = 1'b0;
    // An EOC during a sweep is remembered once; IDLE always consumes it.
    pending_next   = (state_reg == IDLE) ? 1'b0 : (pending_reg | bus.eoc_in);

    case (state_reg)
      IDLE: begin
        if (bus.eoc_in || pending_reg) begin
          state_next = REQ;
          idx_next   = 4'd0;
        end
      end
      REQ: begin
        tcnt_next  = 8'd0;
        state_next = WAIT;
      end
      WAIT: begin
        // tcnt counts WAIT cycles already spent; a drdy arriving in the
        // cycle that would expire the read still wins.
        if (bus.drp_drdy) begin
          sample_next    = bus.drp_do[15:4];
          sample_ch_next = idx_reg;
          state_next     = HOLD;
        end else if (tcnt_reg == TMO) begin
          timeout_hit = 1'b1;
          advance     = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + 8'd1;
        end
      end
      HOLD: begin
        if (bus.sample_ready) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (advance) begin
      if (idx_reg == LAST_IDX) begin
        idx_next   = 4'd0;
        state_next = IDLE;
      end else begin
        idx_next   = idx_reg + 4'd1;
        state_next = REQ;
      end
    end
  end

  assign bus.drp_den      = (state_reg == REQ);
  assign bus.drp_dwe      = 1'b0;
  assign bus.drp_daddr    = BASE_ADDR + {3'b000, idx_reg};
  assign bus.sample       = sample_reg;
  assign bus.sample_ch    = sample_ch_reg;
  assign bus.sample_valid = (state_reg == HOLD);
  assign bus.busy         = (state_reg != IDLE);
  assign bus.timeout_err  = timeout_hit;

endmodule

// File: tb/tb_xadc_channel_sequencer.sv
// Scoreboard bench: a DRP responder model predicts every sample, timeout
// and address; a monitor compares them against the sequencer outputs.
`timescale 1ns/1ps

module tb_xadc_channel_sequencer;
  localparam int         NUM_CH  = 13;
  localparam int         TIMEOUT = 255;
  localparam logic [6:0] BASE    = 7'h10;

  typedef struct {
    int          ch;
    logic [11:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xadc_channel_sequencer_if bus();

  xadc_channel_sequencer #(
    .NUM_CH    (NUM_CH),
    .BASE_ADDR (BASE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  sb_q[$];
  resp_t resp_q[$];
  int    tmo_q[$];
  int    den_log[$];
  int    lat_cfg[NUM_CH];
  bit    fixed_data;
  bit    rand_ready;
  int    cyc       = 0;
  int    den_cnt   = 0;
  int    n_samples = 0;
  int    n_tmo     = 0;
  int    n_tests   = 0;
  int    n_fail    = 0;
  int    e_cyc;

  task automatic check_eq(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // DRP responder drives drdy after posedge; monitor checks at negedge.
  initial begin : monitor
    int          ch;
    int          lat;
    logic [15:0] dv;
    exp_t        e;
    resp_t       r;
    bit          prev_valid;
    bit          prev_acc;
    bit          fresh;
    bit          chk_after_tmo;
    int          last_tmo_cyc;
    prev_valid    = 0;
    prev_acc      = 0;
    chk_after_tmo = 0;
    last_tmo_cyc  = 0;
    bus.drp_drdy  = 1'b0;
    bus.drp_do    = 16'h0000;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.drp_drdy = 1'b0;
      for (int i = 0; i < resp_q.size(); i++) begin
        if (resp_q[i].cyc == cyc) begin
          bus.drp_drdy = 1'b1;
          bus.drp_do   = resp_q[i].data;
          resp_q.delete(i);
          break;
        end
      end
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        resp_q.delete();
        tmo_q.delete();
        den_cnt       = 0;
        prev_valid    = 0;
        prev_acc      = 0;
        chk_after_tmo = 0;
      end else begin
        if (bus.drp_den) begin
          ch  = den_cnt % NUM_CH;
          lat = lat_cfg[ch];
          check_eq("den_addr", bus.drp_daddr, BASE + ch);
          check_eq("den_while_valid", bus.sample_valid, 0);
          if (chk_after_tmo) check_eq("den_after_timeout", cyc, last_tmo_cyc + 1);
          chk_after_tmo = 0;
          den_log.push_back(cyc);
          den_cnt++;
          if (fixed_data) dv = {8'h00, 4'(ch), 4'h0} + 16'h0A50;
          else dv = 16'($urandom);
          if (lat >= 1) begin
            r.cyc  = cyc + lat;
            r.data = dv;
            resp_q.push_back(r);
          end
          if (lat >= 1 && lat <= TIMEOUT + 1) begin
            e.ch   = ch;
            e.data = dv[15:4];
            e.cyc  = cyc + lat + 1;
            sb_q.push_back(e);
          end else begin
            tmo_q.push_back(cyc + TIMEOUT + 1);
          end
        end
        if (bus.timeout_err) begin
          n_tmo++;
          if (tmo_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_unexpected: got timeout_err=1, required 0 (cycle %0d)", cyc);
          end else begin
            check_eq("timeout_cycle", cyc, tmo_q.pop_front());
          end
          last_tmo_cyc  = cyc;
          chk_after_tmo = (den_cnt % NUM_CH) != 0;
        end
        if (bus.sample_valid) begin
          fresh = !prev_valid || prev_acc;
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sample_unexpected: got ch %0d data %h, required no sample (cycle %0d)",
                     bus.sample_ch, bus.sample, cyc);
          end else begin
            check_eq("sample_ch", bus.sample_ch, sb_q[0].ch);
            check_eq("sample_data", bus.sample, sb_q[0].data);
            if (fresh) check_eq("sample_latency", cyc, sb_q[0].cyc);
            if (bus.sample_ready) begin
              void'(sb_q.pop_front());
              n_samples++;
            end
          end
        end
        prev_valid = bus.sample_valid;
        prev_acc   = bus.sample_valid && bus.sample_ready;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.sample_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_eoc();
    @(posedge clk);
    #1;
    bus.eoc_in = 1'b1;
    e_cyc = cyc;
    tick(1);
    bus.eoc_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    int k;
    quiet = 0;
    k = 0;
    while (quiet < 3 && k < 4000) begin
      tick(1);
      k++;
      if (bus.busy) quiet = 0;
      else quiet++;
    end
    check_eq(name, quiet >= 3, 1);
  endtask

  task automatic set_lat(input int lo, input int hi);
    for (int i = 0; i < NUM_CH; i++) lat_cfg[i] = $urandom_range(lo, hi);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s0;
    int d0;
    int t0;
    int li;
    int held;
    int k;
    rst = 1'b1;
    bus.eoc_in = 1'b0;
    bus.sample_ready = 1'b0;
    rand_ready = 0;
    fixed_data = 1;
    set_lat(3, 3);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_den", bus.drp_den, 0);
    check_eq("rst_dwe", bus.drp_dwe, 0);
    check_eq("rst_valid", bus.sample_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_daddr", bus.drp_daddr, 7'h10);
    rst = 1'b0;
    tick(2);

    // Full sweep, fixed pattern, drdy 3 cycles after den, ready high.
    bus.sample_ready = 1'b1;
    s0 = n_samples; d0 = den_cnt; li = den_log.size();
    pulse_eoc();
    wait_idle("sweep_done");
    check_eq("sweep_samples", n_samples - s0, 13);
    check_eq("sweep_dens", den_cnt - d0, 13);
    check_eq("den_after_eoc", den_log[li], e_cyc + 1);

    // Backpressure on channel 4.
    fixed_data = 0;
    set_lat(1, 4);
    s0 = n_samples; d0 = den_cnt;
    pulse_eoc();
    k = 0;
    while (den_cnt < d0 + 5 && k < 300) begin tick(1); k++; end
    bus.sample_ready = 1'b0;
    k = 0;
    while (!bus.sample_valid && k < 50) begin tick(1); k++; end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sample_valid && bus.sample_ch == 4'd4) held++;
      tick(1);
    end
    check_eq("backpressure_hold", held, 20);
    bus.sample_ready = 1'b1;
    wait_idle("bp_done");
    check_eq("bp_samples", n_samples - s0, 13);

    // Channel 7 never answers, random ready.
    set_lat(1, 5);
    lat_cfg[7] = -1;
    rand_ready = 1;
    s0 = n_samples; t0 = n_tmo;
    pulse_eoc();
    wait_idle("tmo_done");
    rand_ready = 0;
    bus.sample_ready = 1'b1;
    check_eq("tmo_count", n_tmo - t0, 1);
    check_eq("tmo_samples", n_samples - s0, 12);

    // Two extra EOCs during one sweep merge into a single extra sweep.
    set_lat(1, 4);
    rand_ready = 1;
    s0 = n_samples; d0 = den_cnt;
    pulse_eoc();
    tick(10);
    pulse_eoc();
    tick(15);
    pulse_eoc();
    wait_idle("overlap_done");
    rand_ready = 0;
    bus.sample_ready = 1'b1;
    check_eq("overlap_samples", n_samples - s0, 26);
    d0 = den_cnt;
    tick(30);
    check_eq("overlap_no_more_den", den_cnt, d0);

    // drdy exactly on the last allowed WAIT cycle wins; one cycle later times out.
    set_lat(2, 2);
    lat_cfg[5] = TIMEOUT + 1;
    lat_cfg[6] = TIMEOUT + 2;
    s0 = n_samples; t0 = n_tmo;
    pulse_eoc();
    wait_idle("edge_done");
    check_eq("edge_samples", n_samples - s0, 12);
    check_eq("edge_tmo_count", n_tmo - t0, 1);

    // EOC in the cycle the sweep completes: one IDLE cycle, then a new sweep.
    set_lat(1, 1);
    s0 = n_samples; li = den_log.size();
    pulse_eoc();
    while (cyc < e_cyc + 38) tick(1);
    tick(1);
    bus.eoc_in = 1'b1;
    tick(1);
    bus.eoc_in = 1'b0;
    wait_idle("eoc_at_end_done");
    check_eq("eoc_at_end_samples", n_samples - s0, 26);
    check_eq("eoc_at_end_restart", den_log[li + 13], e_cyc + 41);

    // Reset in the middle of a WAIT.
    set_lat(2, 2);
    lat_cfg[2] = -1;
    pulse_eoc();
    k = 0;
    while (den_cnt % NUM_CH != 3 && k < 100) begin tick(1); k++; end
    tick(20);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_den", bus.drp_den, 0);
    check_eq("midrst_valid", bus.sample_valid, 0);
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_tmo", bus.timeout_err, 0);
    check_eq("midrst_daddr", bus.drp_daddr, 7'h10);
    tick(2);
    rst = 1'b0;
    s0 = n_samples;
    tick(300);
    check_eq("postrst_samples", n_samples, s0);
    check_eq("postrst_dens", den_cnt, 0);
    check_eq("postrst_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
